// File: rtl/btn_event_pkg.sv
// Shared types and default constants for the button event decoder.
// Optional feature macro: BTN_EVENT_AUTO_REPEAT_EN (auto-repeat pulses while long-held).
package btn_event_pkg;

    // Default hold time before long_press, in clock cycles after the press event
    localparam int unsigned BTN_LONG_CYCLES_DEF   = 1000;
    // Default auto-repeat period while long-held
    localparam int unsigned BTN_REPEAT_CYCLES_DEF = 200;
    // Default hold-counter width; 2^CNT_W must exceed both cycle counts
    localparam int unsigned BTN_CNT_W_DEF         = 16;

    // Decoder states; WAIT_LOW blocks a button held through reset from reporting a press
    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        IDLE     = 2'd1,
        PRESSED  = 2'd2,
        LONG     = 2'd3
    } btn_state_t;

    // True in the states where the button counts as held
    function automatic logic state_is_held(input btn_state_t s);
        return (s == PRESSED) || (s == LONG);
    endfunction

endpackage

// File: rtl/btn_hold_counter.sv
// Hold counter for the button event decoder: synchronous clear, increment
// enable and a terminal-count flag against a caller-selected limit.
// The counter saturates at all-ones so it never wraps.
module btn_hold_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    // Count register: clear has priority over increment; saturate at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Terminal count flag for the currently selected limit
    always_comb begin
        tc = (cnt == limit);
    end

endmodule

// File: rtl/btn_event.sv
// Button event decoder: turns a debounced, synchronous button level into
// one-cycle press / release / long-press / auto-repeat pulses plus a held level.
// Optional feature macro: BTN_EVENT_AUTO_REPEAT_EN. When undefined, repeat_o is
// tied to 0 and the hold counter freezes once the long-held state is reached.
module btn_event
    import btn_event_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = BTN_LONG_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES = BTN_REPEAT_CYCLES_DEF,
    parameter int unsigned CNT_W         = BTN_CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic press,
    output logic release_o,
    output logic long_press,
    output logic repeat_o,
    output logic held
);

    localparam logic [CNT_W-1:0] LONG_LIMIT   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LIMIT = CNT_W'(REPEAT_CYCLES - 1);

    btn_state_t       state_q;
    btn_state_t       state_d;

    logic             press_d;
    logic             release_d;
    logic             long_d;
    logic             repeat_d;

    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_tc;
    logic [CNT_W-1:0] cnt_limit;

    btn_hold_counter #(
        .CNT_W (CNT_W)
    ) u_hold_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .limit (cnt_limit),
        .tc    (cnt_tc)
    );

    // Next-state, counter control and next-cycle event decode
    always_comb begin
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        cnt_limit = (state_q == LONG) ? REPEAT_LIMIT : LONG_LIMIT;

        unique case (state_q)
            WAIT_LOW: begin
                if (!in) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (in) begin
                    state_d = PRESSED;
                    cnt_clr = 1'b1;
                    press_d = 1'b1;
                end
            end
            PRESSED: begin
                if (!in) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else if (cnt_tc) begin
                    state_d = LONG;
                    cnt_clr = 1'b1;
                    long_d  = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            LONG: begin
                if (!in) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else begin
`ifdef BTN_EVENT_AUTO_REPEAT_EN
                    if (cnt_tc) begin
                        cnt_clr  = 1'b1;
                        repeat_d = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
`else
                    cnt_en = 1'b0;
`endif
                end
            end
            default: begin
                state_d = WAIT_LOW;
            end
        endcase
    end

    // State register and registered event outputs; reset drops everything at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WAIT_LOW;
            press      <= 1'b0;
            release_o  <= 1'b0;
            long_press <= 1'b0;
            held       <= 1'b0;
        end else begin
            state_q    <= state_d;
            press      <= press_d;
            release_o  <= release_d;
            long_press <= long_d;
            held       <= state_is_held(state_d);
        end
    end

`ifdef BTN_EVENT_AUTO_REPEAT_EN
    // Registered auto-repeat pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            repeat_o <= 1'b0;
        end else begin
            repeat_o <= repeat_d;
        end
    end
`else
    // Auto-repeat disabled: output held low, decode result unused
    logic repeat_unused;
    always_comb begin
        repeat_unused = repeat_d;
        repeat_o      = 1'b0;
    end
`endif

endmodule

// File: tb/tb_btn_event.sv
// Scoreboard bench for btn_event: randomized button levels, expected events
// derived from hold durations, compared by an independent monitor.
module tb_btn_event;

    localparam int unsigned LONG_CYC = 8;
    localparam int unsigned REP_CYC  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in = 1'b0;
    logic press, release_o, long_press, repeat_o, held;

    always #5 clk = ~clk;

    btn_event #(
        .LONG_CYCLES   (LONG_CYC),
        .REPEAT_CYCLES (REP_CYC),
        .CNT_W         (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in         (in),
        .press      (press),
        .release_o  (release_o),
        .long_press (long_press),
        .repeat_o   (repeat_o),
        .held       (held)
    );

    int checks   = 0;
    int failures = 0;
    int pushed   = 0;
    int popped   = 0;

    // Expected {press, release, long, repeat, held} per sampled edge
    logic [4:0] exp_q[$];

    // Reference: seen-low-since-reset flag, held flag, edges held since the press edge
    bit          m_armed   = 1'b0;
    bit          m_holding = 1'b0;
    int unsigned m_h       = 0;

    task automatic model_step(input bit v, output logic [4:0] e);
        logic p, r, l, rp;
        p = 1'b0; r = 1'b0; l = 1'b0; rp = 1'b0;
        if (!m_armed) begin
            if (!v) m_armed = 1'b1;
        end else if (!m_holding) begin
            if (v) begin
                p = 1'b1;
                m_holding = 1'b1;
                m_h = 0;
            end
        end else if (!v) begin
            r = 1'b1;
            m_holding = 1'b0;
        end else begin
            m_h++;
            if (m_h == LONG_CYC) l = 1'b1;
`ifdef BTN_EVENT_AUTO_REPEAT_EN
            if (m_h > LONG_CYC && ((m_h - LONG_CYC) % REP_CYC) == 0) rp = 1'b1;
`endif
        end
        e = {p, r, l, rp, m_holding};
    endtask

    task automatic step(input bit v);
        logic [4:0] e;
        @(negedge clk);
        in = v;
        model_step(v, e);
        exp_q.push_back(e);
        pushed++;
    endtask

    task automatic hold(input bit v, input int unsigned n);
        repeat (n) step(v);
    endtask

    task automatic check_quiet(input string name);
        logic [4:0] act;
        act = {press, release_o, long_press, repeat_o, held};
        checks++;
        if (act !== 5'b0) begin
            failures++;
            $display("FAIL %s actual=%b required=00000", name, act);
        end
    endtask

    // Monitor: compare DUT outputs just after each edge that has an expectation
    initial begin
        logic [4:0] e, act;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {press, release_o, long_press, repeat_o, held};
                popped++;
                checks++;
                if (act !== e) begin
                    failures++;
                    $display("FAIL events t=%0t actual=%b required=%b (press,release,long,repeat,held)",
                             $time, act, e);
                end
            end
        end
    end

    initial begin
        int unsigned len;
        rst_n = 1'b0;
        in    = 1'b0;
        #12;
        check_quiet("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        hold(0, 2);
        // short press, no long
        hold(1, 3);
        hold(0, 2);
        // long hold with repeats
        hold(1, 20);
        hold(0, 2);
        // release on the terminal-count edge
        hold(1, LONG_CYC);
        hold(0, 2);

        // randomized hold/release segments
        for (int s = 0; s < 40; s++) begin
            case ($urandom_range(0, 3))
                0:       len = $urandom_range(1, 3);
                1:       len = $urandom_range(LONG_CYC - 1, LONG_CYC + 1);
                2:       len = $urandom_range(LONG_CYC + REP_CYC - 1, LONG_CYC + 2 * REP_CYC + 1);
                default: len = $urandom_range(14, 30);
            endcase
            hold(1, len);
            hold(0, $urandom_range(1, 3));
        end

        // async reset while long-held, button kept down through reset release
        hold(1, 14);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_quiet("async_reset");
        m_armed   = 1'b0;
        m_holding = 1'b0;
        m_h       = 0;
        repeat (2) @(negedge clk);
        check_quiet("in_reset");
        rst_n = 1'b1;
        hold(1, 10);
        hold(0, 1);
        hold(1, 3);
        hold(0, 2);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || popped != pushed) begin
            failures++;
            $display("FAIL drain actual=%0d popped, %0d queued required=%0d popped, 0 queued",
                     popped, exp_q.size(), pushed);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
